// File: rtl/stack_frame_seq_pkg.sv
// Shared definitions for the context-stack sequencer and its bound checker.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
// Contents: op_e (PUSH/POP opcode), state_e (sequencer state encoding).
package stack_pkg;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/stack_frame_seq_if.sv
// Data-memory request/acknowledge bus used by the stack sequencer.
// Latency: none (signal bundle only).
// Backpressure: requester holds strobe/address/data until mem_ack is seen.
// Ports: master drives mem_addr/mem_wdata/mem_wr/mem_rd; slave returns mem_rdata/mem_ack.
interface stack_frame_seq_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_wr, mem_rd,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wr, mem_rd,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/stack_frame_seq_bound_check.sv
// Stack overflow/underflow pre-check for a whole frame, before any memory access.
// Latency: purely combinational.
// Backpressure: none; reject_o is a pure function of sp_i/op_i.
// Ports: sp_i (current SP, next free slot), op_i (PUSH/POP), reject_o (frame would leave the stack window).
module stack_bound_check
    import stack_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                FRAME_WORDS = 2,
    parameter logic [ADDR_W-1:0] SP_RESET    = 8'hFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'h80
) (
    input  logic [ADDR_W-1:0] sp_i,
    input  op_e               op_i,
    output logic              reject_o
);

    // One extra bit keeps SP+FRAME_WORDS from wrapping. The push test is
    // rearranged as SP < LIMIT+(FRAME_WORDS-1) so a small SP cannot wrap either.
    localparam logic [ADDR_W:0] PUSH_MIN = {1'b0, STACK_LIMIT} + (ADDR_W+1)'(FRAME_WORDS - 1);
    localparam logic [ADDR_W:0] POP_MAX  = {1'b0, SP_RESET};

    logic [ADDR_W:0] sp_ext;
    logic [ADDR_W:0] pop_end;

    assign sp_ext  = {1'b0, sp_i};
    assign pop_end = sp_ext + (ADDR_W+1)'(FRAME_WORDS);

    always_comb begin
        reject_o = 1'b0;
        if (op_i == OP_POP) begin
            reject_o = (pop_end > POP_MAX);
        end else begin
            reject_o = (sp_ext < PUSH_MIN);
        end
    end

endmodule

// File: rtl/stack_frame_seq.sv
// Context-stack sequencer: pushes/pops a FRAME_WORDS-word frame over the memory bus and owns SP.
// Latency: start -> done in FRAME_WORDS+2 cycles with zero-wait ack (2 cycles when rejected); +1 per wait cycle.
// Backpressure: each beat holds its strobe until mem_ack; start/sp_load are ignored while busy_o is high.
// Ports: clk/rst (sync, active-high); start_i/op_i/frame_in_i request; frame_out_o/busy_o/done_o/err_o status;
//        sp_o, sp_load_i/sp_load_val_i stack-pointer access; mem (master) data-memory bus.
module stack_frame_seq
    import stack_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                FRAME_WORDS = 2,
    parameter logic [ADDR_W-1:0] SP_RESET    = 8'hFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'h80
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          op_i,
    input  logic [FRAME_WORDS*DATA_W-1:0] frame_in_i,
    output logic [FRAME_WORDS*DATA_W-1:0] frame_out_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [ADDR_W-1:0]             sp_o,
    input  logic                          sp_load_i,
    input  logic [ADDR_W-1:0]             sp_load_val_i,
    stack_frame_seq_if.master             mem
);

    localparam int              CNT_W     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_WORDS - 1);

    state_e                   state_q;
    op_e                      op_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [DATA_W-1:0]        frame_q [FRAME_WORDS];
    logic [FRAME_WORDS*DATA_W-1:0] frame_out_q;
    logic [ADDR_W-1:0]        sp_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        wdata_q;
    logic                     wr_q;
    logic                     rd_q;

    logic                          reject;
    logic                          last_beat;
    logic [CNT_W-1:0]              push_idx_d;
    logic [FRAME_WORDS*DATA_W-1:0] frame_packed_d;

    stack_bound_check #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS),
        .SP_RESET    (SP_RESET),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_bound (
        .sp_i     (sp_q),
        .op_i     (op_q),
        .reject_o (reject)
    );

    assign last_beat = (cnt_q == LAST_BEAT);
    // Push walks the captured frame from the top word down; this is the word
    // for the beat after the current one (only used when not on the last beat).
    assign push_idx_d = LAST_BEAT - cnt_q - CNT_W'(1);

    always_comb begin
        frame_packed_d = '0;
        for (int k = 0; k < FRAME_WORDS; k++) begin
            frame_packed_d[k*DATA_W +: DATA_W] = frame_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_PUSH;
            cnt_q       <= '0;
            for (int k = 0; k < FRAME_WORDS; k++) begin
                frame_q[k] <= '0;
            end
            frame_out_q <= '0;
            sp_q        <= SP_RESET;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // SP load has priority; a coincident start is dropped.
                    if (sp_load_i) begin
                        sp_q <= sp_load_val_i;
                    end else if (start_i) begin
                        op_q   <= op_e'(op_i);
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        for (int k = 0; k < FRAME_WORDS; k++) begin
                            frame_q[k] <= frame_in_i[k*DATA_W +: DATA_W];
                        end
                        state_q <= CHECK;
                    end
                end

                CHECK: begin
                    if (reject) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= XFER;
                        if (op_q == OP_PUSH) begin
                            wr_q    <= 1'b1;
                            addr_q  <= sp_q;
                            wdata_q <= frame_q[LAST_BEAT];
                        end else begin
                            rd_q   <= 1'b1;
                            addr_q <= sp_q + ADDR_W'(1);
                        end
                    end
                end

                XFER: begin
                    if (mem.mem_ack) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (op_q == OP_PUSH) begin
                            sp_q <= sp_q - ADDR_W'(1);
                        end else begin
                            // Pop address is already SP+1, i.e. the new SP.
                            sp_q           <= addr_q;
                            frame_q[cnt_q] <= mem.mem_rdata;
                        end

                        if (last_beat) begin
                            wr_q    <= 1'b0;
                            rd_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (op_q == OP_PUSH) begin
                            addr_q  <= sp_q - ADDR_W'(1);
                            wdata_q <= frame_q[push_idx_d];
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end

                DONE: begin
                    if ((op_q == OP_POP) && !err_q) begin
                        frame_out_q <= frame_packed_d;
                    end
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame_out_o   = frame_out_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign sp_o          = sp_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_rd    = rd_q;

endmodule

// File: tb/tb_stack_frame_seq.sv
module tb_stack_frame_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] frame_in;
    logic [15:0] frame_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  sp;
    logic        sp_load;
    logic [7:0]  sp_load_val;

    stack_frame_seq_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    stack_frame_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .op_i          (op),
        .frame_in_i    (frame_in),
        .frame_out_o   (frame_out),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .sp_o          (sp),
        .sp_load_i     (sp_load),
        .sp_load_val_i (sp_load_val),
        .mem           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] mem_arr [256];
    int         ack_delay = 0;
    int         wait_cnt = 0;
    int         strobe_cycles = 0;
    logic [7:0] hold_addr;
    logic [7:0] hold_wdata;
    logic       hold_wr;
    logic       hold_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Memory responder: acks after ack_delay wait cycles, checks stability
    // while stalled, and checks each completed beat against the scoreboard.
    always @(negedge clk) begin
        if (rst || !(bus.mem_wr || bus.mem_rd)) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'h00;
            wait_cnt      = 0;
        end else begin
            strobe_cycles++;
            if (wait_cnt == 0) begin
                hold_addr  = bus.mem_addr;
                hold_wdata = bus.mem_wdata;
                hold_wr    = bus.mem_wr;
                hold_rd    = bus.mem_rd;
            end else begin
                chk("stall_stable", {bus.mem_addr, bus.mem_wdata, 6'd0, bus.mem_wr, bus.mem_rd},
                    {hold_addr, hold_wdata, 6'd0, hold_wr, hold_rd});
            end
            if (wait_cnt == ack_delay) begin
                bus.mem_ack = 1'b1;
                wait_cnt    = 0;
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_kind", {bus.mem_wr, bus.mem_rd}, {e.wr, ~e.wr});
                    chk("beat_addr", bus.mem_addr, e.addr);
                    if (e.wr) chk("beat_wdata", bus.mem_wdata, e.data);
                end
                if (bus.mem_wr) mem_arr[bus.mem_addr] = bus.mem_wdata;
                bus.mem_rdata = mem_arr[bus.mem_addr];
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    task automatic expect_push(input logic [7:0] s, input logic [15:0] f);
        beat_t b;
        b.wr = 1'b1; b.addr = s;         b.data = f[15:8]; exp_q.push_back(b);
        b.wr = 1'b1; b.addr = s - 8'd1;  b.data = f[7:0];  exp_q.push_back(b);
    endtask

    task automatic expect_pop(input logic [7:0] s);
        beat_t b;
        b.wr = 1'b0; b.addr = s + 8'd1; b.data = 8'h00; exp_q.push_back(b);
        b.wr = 1'b0; b.addr = s + 8'd2; b.data = 8'h00; exp_q.push_back(b);
    endtask

    // Start sampled at edge 0; returns the cycle in which done is seen (-1 on timeout).
    task automatic run_op(input logic o, input logic [15:0] f, input int dly,
                          output int dcyc, output logic derr);
        ack_delay = dly;
        dcyc = -1;
        derr = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; frame_in = f;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) chk("busy_in_check", busy, 1);
            if (done) begin
                dcyc = c;
                derr = err;
                break;
            end
        end
        @(negedge clk);
        chk("idle_after_done", {busy, done, err}, 3'b000);
    endtask

    task automatic load_sp(input logic [7:0] v);
        @(negedge clk);
        sp_load = 1'b1; sp_load_val = v;
        @(negedge clk);
        sp_load = 1'b0;
    endtask

    initial begin
        int   dc;
        logic de;
        int   s0;
        int   seen;

        rst = 1'b1; start = 1'b0; op = 1'b0; frame_in = 16'h0;
        sp_load = 1'b0; sp_load_val = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sp", sp, 8'hFF);
        chk("rst_flags", {busy, done, err, bus.mem_wr, bus.mem_rd}, 5'b0);
        chk("rst_frame_out", frame_out, 16'h0);
        chk("rst_addr", bus.mem_addr, 8'h0);
        chk("rst_wdata", bus.mem_wdata, 8'h0);
        rst = 1'b0;

        // Zero-wait push then pop.
        expect_push(8'hFF, 16'hA53C);
        run_op(1'b0, 16'hA53C, 0, dc, de);
        chk("push_done_cycle", dc, 4);
        chk("push_err", de, 0);
        chk("push_sp", sp, 8'hFD);
        chk("push_sb_empty", exp_q.size(), 0);

        expect_pop(8'hFD);
        run_op(1'b1, 16'h0, 0, dc, de);
        chk("pop_done_cycle", dc, 4);
        chk("pop_err", de, 0);
        chk("pop_frame_out", frame_out, 16'hA53C);
        chk("pop_sp", sp, 8'hFF);
        chk("pop_sb_empty", exp_q.size(), 0);

        // Three wait cycles per beat.
        expect_push(8'hFF, 16'h1234);
        run_op(1'b0, 16'h1234, 3, dc, de);
        chk("stall_push_cycle", dc, 10);
        chk("stall_push_sp", sp, 8'hFD);
        expect_pop(8'hFD);
        run_op(1'b1, 16'h0, 3, dc, de);
        chk("stall_pop_cycle", dc, 10);
        chk("stall_pop_frame", frame_out, 16'h1234);
        chk("stall_pop_sp", sp, 8'hFF);

        // Overflow: frame would go below STACK_LIMIT.
        load_sp(8'h80);
        chk("load_sp", sp, 8'h80);
        s0 = strobe_cycles;
        run_op(1'b0, 16'hBEEF, 0, dc, de);
        chk("ovf_cycle", dc, 2);
        chk("ovf_err", de, 1);
        chk("ovf_sp", sp, 8'h80);
        chk("ovf_no_strobe", strobe_cycles - s0, 0);

        // Underflow: pop from an empty stack.
        load_sp(8'hFF);
        s0 = strobe_cycles;
        run_op(1'b1, 16'h0, 0, dc, de);
        chk("unf_cycle", dc, 2);
        chk("unf_err", de, 1);
        chk("unf_frame_kept", frame_out, 16'h1234);
        chk("unf_sp", sp, 8'hFF);
        chk("unf_no_strobe", strobe_cycles - s0, 0);

        // sp_load and start together: load wins, start dropped.
        s0 = strobe_cycles;
        @(negedge clk);
        sp_load = 1'b1; sp_load_val = 8'h90; start = 1'b1; op = 1'b0; frame_in = 16'hFFFF;
        @(negedge clk);
        sp_load = 1'b0; start = 1'b0;
        chk("conc_sp", sp, 8'h90);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        chk("conc_no_op", seen, 0);
        chk("conc_no_strobe", strobe_cycles - s0, 0);

        // Reset during cycle 2 of a push.
        expect_push(8'h90, 16'h5A5A);
        ack_delay = 0;
        @(negedge clk);
        start = 1'b1; op = 1'b0; frame_in = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_strobes", {bus.mem_wr, bus.mem_rd}, 2'b00);
        chk("midrst_flags", {busy, done, err}, 3'b000);
        chk("midrst_sp", sp, 8'hFF);
        rst = 1'b0;
        exp_q.delete();

        // Normal operation resumes after reset.
        expect_push(8'hFF, 16'h0F0F);
        run_op(1'b0, 16'h0F0F, 0, dc, de);
        chk("post_rst_cycle", dc, 4);
        chk("post_rst_sp", sp, 8'hFD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
